// File: rtl/rc4_pkg.sv
// RC4 shared types and constants.
// Holds the KSA state enum and the KSA control bundle.
package rc4_pkg;

  localparam int KEY_BYTES = 3;
  localparam int S_DEPTH   = 256;
  localparam int MSG_LEN   = 32;

  typedef enum logic [2:0] {
    IDLE,
    READ_I,
    LATCH_I,
    READ_J,
    LATCH_J,
    WRITE_I,
    WRITE_J
  } ksa_state_t;

  // sel_addr: [0]=i, [1]=j, none=0
  // sel_data: [0]=s_j, [1]=s_i, none=0
  typedef struct packed {
    logic       load;
    logic       inc_i;
    logic       store_j;
    logic       store_s_i;
    logic       store_s_j;
    logic [1:0] sel_addr;
    logic [1:0] sel_data;
  } ksa_ctl_t;

endpackage

// File: rtl/ksa_datapath.sv
// KSA datapath: i/j/kidx/s_i/s_j/key registers, S-memory muxes.
// Ports: clk, rst, ctl strobes, key, s_rddata in; s_addr, s_wrdata, i_last out.
module ksa_datapath
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  ksa_ctl_t               ctl,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [DATA_W-1:0]      s_rddata,
  output logic [ADDR_W-1:0]      s_addr,
  output logic [DATA_W-1:0]      s_wrdata,
  output logic                   i_last
);

  localparam int KW =
    (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  logic [ADDR_W-1:0]      i_q, i_d;
  logic [ADDR_W-1:0]      j_q, j_d;
  logic [KW-1:0]          kidx_q, kidx_d;
  logic [DATA_W-1:0]      s_i_q, s_i_d;
  logic [DATA_W-1:0]      s_j_q, s_j_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [7:0]             key_byte;

  // byte 0 sits in the top byte of the key word
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (kidx_q == KW'(k)) begin
        key_byte = key_q[8*(KEY_BYTES-1-k) +: 8];
      end
    end
  end

  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    kidx_d = kidx_q;
    s_i_d  = s_i_q;
    s_j_d  = s_j_q;
    key_d  = key_q;
    if (ctl.load) begin
      key_d  = key;
      i_d    = '0;
      j_d    = '0;
      kidx_d = '0;
    end
    if (ctl.store_j) begin
      j_d = j_q + ADDR_W'(s_rddata)
                + ADDR_W'(key_byte);
    end
    if (ctl.store_s_i) begin
      s_i_d = s_rddata;
    end
    if (ctl.store_s_j) begin
      s_j_d = s_rddata;
    end
    if (ctl.inc_i) begin
      i_d = i_q + ADDR_W'(1);
      if (kidx_q == KW'(KEY_BYTES-1)) begin
        kidx_d = '0;
      end else begin
        kidx_d = kidx_q + KW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q    <= '0;
      j_q    <= '0;
      kidx_q <= '0;
      s_i_q  <= '0;
      s_j_q  <= '0;
      key_q  <= '0;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      kidx_q <= kidx_d;
      s_i_q  <= s_i_d;
      s_j_q  <= s_j_d;
      key_q  <= key_d;
    end
  end

  always_comb begin
    s_addr = '0;
    unique case (1'b1)
      ctl.sel_addr[0]: s_addr = i_q;
      ctl.sel_addr[1]: s_addr = j_q;
      default:         s_addr = '0;
    endcase
  end

  always_comb begin
    s_wrdata = '0;
    unique case (1'b1)
      ctl.sel_data[0]: s_wrdata = s_j_q;
      ctl.sel_data[1]: s_wrdata = s_i_q;
      default:         s_wrdata = '0;
    endcase
  end

  assign i_last = (i_q == '1);

endmodule

// File: rtl/ksa_engine.sv
// RC4 key-scheduling engine: permutes S in place with the key.
// Ports: clk, rst, en/rdy handshake, key, single-port S memory.
module ksa_engine
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [ADDR_W-1:0]      s_addr,
  output logic [DATA_W-1:0]      s_wrdata,
  output logic                   s_wren,
  input  logic [DATA_W-1:0]      s_rddata
);

  ksa_state_t state_q, state_d;
  ksa_ctl_t   ctl;
  logic       i_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctl     = '0;
    s_wren  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          ctl.load = 1'b1;
          state_d  = READ_I;
        end
      end
      READ_I: begin
        ctl.sel_addr = 2'b01;
        state_d      = LATCH_I;
      end
      LATCH_I: begin
        ctl.sel_addr  = 2'b01;
        ctl.store_s_i = 1'b1;
        ctl.store_j   = 1'b1;
        state_d       = READ_J;
      end
      READ_J: begin
        ctl.sel_addr = 2'b10;
        state_d      = LATCH_J;
      end
      LATCH_J: begin
        ctl.sel_addr  = 2'b10;
        ctl.store_s_j = 1'b1;
        state_d       = WRITE_I;
      end
      WRITE_I: begin
        ctl.sel_addr = 2'b01;
        ctl.sel_data = 2'b01;
        s_wren       = 1'b1;
        state_d      = WRITE_J;
      end
      WRITE_J: begin
        ctl.sel_addr = 2'b10;
        ctl.sel_data = 2'b10;
        s_wren       = 1'b1;
        if (i_last) begin
          state_d = IDLE;
        end else begin
          ctl.inc_i = 1'b1;
          state_d   = READ_I;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdy = (state_q == IDLE);

  ksa_datapath #(
    .KEY_BYTES (KEY_BYTES),
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .ctl      (ctl),
    .key      (key),
    .s_rddata (s_rddata),
    .s_addr   (s_addr),
    .s_wrdata (s_wrdata),
    .i_last   (i_last)
  );

endmodule

// File: tb/tb_ksa_engine.sv
// Bench for ksa_engine: S-memory model, golden KSA,
// write-trace scoreboard and final-S comparison.
module tb_ksa_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [23:0] key = '0;
  logic        rdy;
  logic [7:0]  s_addr;
  logic [7:0]  s_wrdata;
  logic        s_wren;
  logic [7:0]  s_rddata;

  ksa_engine #(
    .KEY_BYTES (3),
    .DATA_W    (8),
    .ADDR_W    (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rdy      (rdy),
    .key      (key),
    .s_addr   (s_addr),
    .s_wrdata (s_wrdata),
    .s_wren   (s_wren),
    .s_rddata (s_rddata)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic       do_init = 1'b0;

  always @(posedge clk) begin
    if (do_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (s_wren) begin
      mem[s_addr] <= s_wrdata;
    end
    s_rddata <= mem[s_addr];
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  logic [15:0] exp_q [$];
  logic [7:0]  gs [256];
  logic [7:0]  log_a [4096];
  logic [7:0]  log_d [4096];
  int          wr_n = 0;

  always @(negedge clk) begin
    logic [15:0] e;
    if (s_wren === 1'b1) begin
      if (wr_n < 4096) begin
        log_a[wr_n] = s_addr;
        log_d[wr_n] = s_wrdata;
      end
      wr_n++;
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", s_addr, e[15:8]);
        chk("wr_data", s_wrdata, e[7:0]);
      end
    end
  end

  task automatic init_s();
    @(negedge clk);
    do_init = 1'b1;
    for (int k = 0; k < 256; k++) gs[k] = 8'(k);
    @(negedge clk);
    do_init = 1'b0;
  endtask

  // golden software KSA on gs, queuing the write trace
  task automatic model(input logic [23:0] k);
    logic [7:0] j, t, kb;
    logic [23:0] kw;
    j = 0;
    for (int i = 0; i < 256; i++) begin
      kw = k >> (8 * (2 - (i % 3)));
      kb = kw[7:0];
      j  = j + gs[i] + kb;
      t  = gs[i];
      exp_q.push_back({8'(i), gs[j]});
      exp_q.push_back({j, t});
      gs[i] = gs[j];
      gs[j] = t;
    end
  endtask

  // call at a negedge with rdy=1
  task automatic start(input logic [23:0] k);
    key = k;
    model(k);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_done(input int en_at,
                           input int key_at,
                           input int rst_at,
                           output int cnt);
    cnt = 0;
    while (rdy !== 1'b1 && cnt < 4000) begin
      cnt++;
      en = (cnt == en_at);
      if (cnt == key_at) key = 24'hFFFFFF;
      if (cnt == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rdy", rdy, 1);
        chk("rst_wren", s_wren, 0);
        chk("rst_addr", s_addr, 0);
        chk("rst_wrdata", s_wrdata, 0);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    en = 1'b0;
    if (cnt >= 4000) chk("timeout", 1, 0);
  endtask

  task automatic check_final();
    for (int k = 0; k < 256; k++) begin
      chk("final_s", mem[k], gs[k]);
    end
    chk("q_empty", exp_q.size(), 0);
  endtask

  int cnt;
  int base;

  initial begin
    @(negedge clk);
    chk("rst_rdy0", rdy, 1);
    chk("rst_wren0", s_wren, 0);
    chk("rst_addr0", s_addr, 0);
    chk("rst_wrdata0", s_wrdata, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("idle_rdy", rdy, 1);
      chk("idle_wren", s_wren, 0);
      chk("idle_addr", s_addr, 0);
    end

    // key 0: i==j iterations at the start
    init_s();
    base = wr_n;
    start(24'h000000);
    wait_done(0, 0, 0, cnt);
    chk("lat_k0", cnt, 1536);
    chk("nwr_k0", wr_n - base, 512);
    chk("k0_a0", log_a[base+0], 0);
    chk("k0_d0", log_d[base+0], 0);
    chk("k0_a1", log_a[base+1], 0);
    chk("k0_d1", log_d[base+1], 0);
    chk("k0_a2", log_a[base+2], 1);
    chk("k0_d2", log_d[base+2], 1);
    chk("k0_a3", log_a[base+3], 1);
    chk("k0_d3", log_d[base+3], 1);
    chk("k0_a4", log_a[base+4], 2);
    chk("k0_d4", log_d[base+4], 3);
    chk("k0_a5", log_a[base+5], 3);
    chk("k0_d5", log_d[base+5], 2);
    check_final();

    // key 010203, en pulse mid-run, then back-to-back run
    init_s();
    base = wr_n;
    start(24'h010203);
    wait_done(50, 0, 0, cnt);
    chk("lat_k1", cnt, 1536);
    chk("nwr_k1", wr_n - base, 512);
    chk("k1_a0", log_a[base+0], 0);
    chk("k1_d0", log_d[base+0], 1);
    chk("k1_a1", log_a[base+1], 1);
    chk("k1_d1", log_d[base+1], 0);
    check_final();
    base = wr_n;
    start(24'hA5C3E1);
    wait_done(0, 0, 0, cnt);
    chk("lat_b2b", cnt, 1536);
    chk("nwr_b2b", wr_n - base, 512);
    check_final();

    // key changes at cycle 100: latched copy used
    init_s();
    start(24'h3C5A96);
    wait_done(0, 100, 0, cnt);
    chk("lat_kchg", cnt, 1536);
    check_final();

    // reset at cycle 700, then re-init and clean run
    init_s();
    start(24'h123456);
    wait_done(0, 0, 700, cnt);
    chk("rst_idle_rdy", rdy, 1);
    init_s();
    start(24'h0A0B0C);
    wait_done(0, 0, 0, cnt);
    chk("lat_post_rst", cnt, 1536);
    check_final();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
